// File: rtl/cdc_level_req_tx.sv
// Source-side controller of the two-level low-power synchronizer path (clk_a domain).
// Captures an upstream word, runs a 4-phase req/ack level handshake and gates the sync-chain clocks.
module cdc_level_req_tx #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned IDLE_HOLD   = 4
) (
    input  logic              clk_a,
    input  logic              rst_n_a,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_rdy,
    output logic              req,
    output logic [DATA_W-1:0] data_out,
    input  logic              ack_async,
    output logic              level_en,
    output logic              busy,
    output logic              err
);

    localparam int unsigned CNT_W = (IDLE_HOLD < 1) ? 1 : $clog2(IDLE_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAKE,
        S_REQ,
        S_RELEASE
    } state_t;

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic                   level_en_q, level_en_d;
    logic                   err_q, err_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_dec;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   accept;

    assign ack_s  = sync_q[SYNC_STAGES-1];
    assign in_rdy = rst_n_a & (state_q == S_IDLE) & ~ack_s;
    assign accept = in_vld & in_rdy;

    assign req      = req_q;
    assign level_en = level_en_q;
    assign data_out = data_q;
    assign err      = err_q;
    assign busy     = (state_q != S_IDLE);

    always_ff @(posedge clk_a) begin
        if (!rst_n_a) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack_async};
        end
    end

    // Saturating countdown; level_en follows the post-decrement value so it
    // stays high for exactly IDLE_HOLD cycles after returning to IDLE.
    assign cnt_dec = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        level_en_d = level_en_q;
        err_d      = err_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d    = S_WAKE;
                    data_d     = in_data;
                    level_en_d = 1'b1;
                end else begin
                    cnt_d      = cnt_dec;
                    level_en_d = (cnt_dec != '0);
                end
            end
            S_WAKE: begin
                state_d = S_REQ;
                req_d   = 1'b1;
                if (ack_s) begin
                    err_d = 1'b1;
                end
            end
            S_REQ: begin
                if (ack_s) begin
                    state_d = S_RELEASE;
                    req_d   = 1'b0;
                end
            end
            S_RELEASE: begin
                if (!ack_s) begin
                    state_d    = S_IDLE;
                    cnt_d      = CNT_W'(IDLE_HOLD);
                    level_en_d = (IDLE_HOLD != 0);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_a) begin
        if (!rst_n_a) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            level_en_q <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            level_en_q <= level_en_d;
            err_q      <= err_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cdc_level_req_tx.sv
// Directed bench for cdc_level_req_tx: transaction-level reference model compared every cycle,
// plus literal checkpoints for the reset, single/back-to-back transfer, idle-hold, stale-ack and error cases.
module tb_cdc_level_req_tx;

    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int HOLD = 4;

    logic          clk_a = 1'b0;
    logic          rst_n_a;
    logic          in_vld;
    logic [DW-1:0] in_data;
    logic          in_rdy;
    logic          req;
    logic [DW-1:0] data_out;
    logic          ack_async;
    logic          level_en;
    logic          busy;
    logic          err;

    logic man_ack  = 1'b0;
    logic dest_ack = 1'b0;
    logic auto_ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_a = ~clk_a;

    // Destination stand-in: echoes req back as ack one cycle later.
    always @(posedge clk_a) dest_ack <= req;
    assign ack_async = auto_ack ? dest_ack : man_ack;

    cdc_level_req_tx #(
        .DATA_W     (DW),
        .SYNC_STAGES(SYNC),
        .IDLE_HOLD  (HOLD)
    ) dut (
        .clk_a    (clk_a),
        .rst_n_a  (rst_n_a),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .req      (req),
        .data_out (data_out),
        .ack_async(ack_async),
        .level_en (level_en),
        .busy     (busy),
        .err      (err)
    );

    // Reference model: phase 0 idle, 1 wake, 2 requesting, 3 releasing.
    int            m_phase = 0;
    int            m_hold  = 0;
    logic          m_req   = 1'b0;
    logic          m_len   = 1'b0;
    logic          m_err   = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic [31:0]   ack_past = '0;
    logic [DW-1:0] accq[$];
    logic          m_ack_s;
    logic          m_rdy;

    // The ack the controller reacts to is what ack_async was SYNC edges ago (zero across reset).
    assign m_ack_s = ack_past[SYNC-1];
    assign m_rdy   = rst_n_a && (m_phase == 0) && !m_ack_s;

    always @(posedge clk_a) begin
        if (!rst_n_a) begin
            m_phase  = 0;
            m_hold   = 0;
            m_req    = 1'b0;
            m_len    = 1'b0;
            m_err    = 1'b0;
            m_data   = '0;
            ack_past = '0;
        end else begin
            case (m_phase)
                0: begin
                    if (in_vld && m_rdy) begin
                        m_phase = 1;
                        m_data  = in_data;
                        m_len   = 1'b1;
                        accq.push_back(in_data);
                    end else begin
                        if (m_hold > 0) m_hold = m_hold - 1;
                        m_len = (m_hold > 0);
                    end
                end
                1: begin
                    if (m_ack_s) m_err = 1'b1;
                    m_phase = 2;
                    m_req   = 1'b1;
                end
                2: if (m_ack_s) begin
                    m_phase = 3;
                    m_req   = 1'b0;
                end
                default: if (!m_ack_s) begin
                    m_phase = 0;
                    m_hold  = HOLD;
                    m_len   = (HOLD > 0);
                end
            endcase
            ack_past = {ack_past[30:0], ack_async};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("in_rdy",   32'(in_rdy),   32'(m_rdy));
        chk("req",      32'(req),      32'(m_req));
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("level_en", 32'(level_en), 32'(m_len));
        chk("busy",     32'(busy),     32'(m_phase != 0));
        chk("err",      32'(err),      32'(m_err));
    endtask

    // Advance n clock edges; every cycle is compared 1 time unit after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_a);
            #1;
            compare_all();
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (m_phase != 0 && k < 50) begin
            tick(1);
            k++;
        end
        chk(name, 32'(k < 50), 32'd1);
    endtask

    initial begin
        rst_n_a = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;

        // T1 reset
        tick(3);
        chk("t1_req", 32'(req), 0);
        chk("t1_len", 32'(level_en), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_err", 32'(err), 0);
        chk("t1_data", 32'(data_out), 0);
        chk("t1_rdy_in_rst", 32'(in_rdy), 0);
        rst_n_a = 1'b1;
        #1;
        chk("t1_rdy_after", 32'(in_rdy), 1);
        tick(1);

        // T2 single transfer, manual ack
        in_vld  = 1'b1;
        in_data = 8'hA5;
        tick(1);
        chk("t2_len_e1", 32'(level_en), 1);
        chk("t2_data_e1", 32'(data_out), 32'h A5);
        chk("t2_rdy_e1", 32'(in_rdy), 0);
        in_vld  = 1'b0;
        in_data = 8'h00;
        tick(1);
        chk("t2_req_e2", 32'(req), 1);
        tick(3);
        man_ack = 1'b1;
        tick(2);
        chk("t2_req_e7", 32'(req), 1);
        tick(1);
        chk("t2_req_e8", 32'(req), 0);
        tick(1);
        man_ack = 1'b0;
        tick(2);
        chk("t2_rdy_e11", 32'(in_rdy), 0);
        tick(1);
        chk("t2_rdy_e12", 32'(in_rdy), 1);
        chk("t2_data_e12", 32'(data_out), 32'h A5);
        tick(3);
        chk("t2_len_e15", 32'(level_en), 1);
        tick(1);
        chk("t2_len_e16", 32'(level_en), 0);

        // T3 back-to-back with held in_vld
        auto_ack = 1'b1;
        accq.delete();
        in_vld  = 1'b1;
        in_data = 8'h01;
        tick(1);
        chk("t3_data1", 32'(data_out), 32'h01);
        in_data = 8'h02;
        begin
            int k;
            k = 0;
            while (accq.size() < 2 && k < 40) begin
                tick(1);
                k++;
            end
        end
        in_vld = 1'b0;
        chk("t3_count", 32'(accq.size()), 2);
        if (accq.size() == 2) begin
            chk("t3_first", 32'(accq[0]), 32'h01);
            chk("t3_second", 32'(accq[1]), 32'h02);
        end
        chk("t3_data2", 32'(data_out), 32'h02);
        wait_idle("t3_idle_timeout");

        // T4 reload during idle-hold countdown
        tick(2);
        in_vld  = 1'b1;
        in_data = 8'h5A;
        tick(1);
        in_vld = 1'b0;
        chk("t4_data", 32'(data_out), 32'h5A);
        for (int i = 0; i < 6; i++) begin
            chk("t4_len_held", 32'(level_en), 1);
            tick(1);
        end
        wait_idle("t4_idle_timeout");
        tick(HOLD + 1);
        chk("t4_len_drop", 32'(level_en), 0);
        chk("t4_count", 32'(accq.size()), 3);

        // T5 stale ack across reset release
        auto_ack = 1'b0;
        man_ack  = 1'b1;
        rst_n_a  = 1'b0;
        tick(3);
        rst_n_a = 1'b1;
        tick(3);
        chk("t5_rdy_blocked", 32'(in_rdy), 0);
        chk("t5_err", 32'(err), 0);
        man_ack = 1'b0;
        tick(1);
        chk("t5_rdy_still", 32'(in_rdy), 0);
        tick(2);
        chk("t5_rdy_free", 32'(in_rdy), 1);
        chk("t5_err_after", 32'(err), 0);

        // T6 ack during WAKE, then reset from REQ
        man_ack = 1'b1;
        tick(1);
        in_vld  = 1'b1;
        in_data = 8'h3C;
        tick(1);
        in_vld = 1'b0;
        chk("t6_busy", 32'(busy), 1);
        tick(1);
        chk("t6_err", 32'(err), 1);
        chk("t6_req", 32'(req), 1);
        rst_n_a = 1'b0;
        tick(1);
        chk("t6_req_rst", 32'(req), 0);
        chk("t6_err_rst", 32'(err), 0);
        chk("t6_data_rst", 32'(data_out), 0);
        chk("t6_len_rst", 32'(level_en), 0);
        man_ack = 1'b0;
        rst_n_a = 1'b1;
        tick(4);
        chk("t6_rdy_end", 32'(in_rdy), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
